fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V core. It holds the PC, issues single-outstanding requests to instruction memory, and presents the fetched instruction with its PC to the decode stage. The decode stage's main decoder consumes `opcode`/`instr`, and this block consumes that decoder's `pc_src` redirect and the hazard unit's `stall`. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

---
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch. Holds the PC, keeps at most one
// instruction-memory request in flight, and hands the fetched word plus its
// PC to decode through an output register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid
);

    // IDLE: nothing in flight; WAIT: a request is in flight and its data is
    // wanted; DROP: a request is in flight but a redirect made it stale.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] instr_pc_reg, instr_pc_next;
    logic        instr_valid_reg, instr_valid_next;
    logic [31:0] buf_instr_reg, buf_instr_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic        buf_valid_reg, buf_valid_next;

    logic        req_fire;
    logic        slot_free;
    logic        resp_live;
    logic        resp_to_out;
    logic        resp_to_buf;
    logic [31:0] target_aligned;

    // The low two bits of the redirect address carry no meaning for a
    // word-aligned fetch, so they are masked off rather than sliced away.
    assign target_aligned = pc_target & 32'hFFFF_FFFC;

    // The output slot can take a new word if it is empty or decode is
    // consuming the current one this cycle.
    assign slot_free   = !instr_valid_reg || !stall;

    // A response is only useful in WAIT and only if no redirect kills it.
    assign resp_live   = (state_reg == WAIT) && imem_valid && !pc_src;
    assign resp_to_out = resp_live && slot_free;
    assign resp_to_buf = resp_live && !slot_free;

    // Next-state logic and request generation for the fetch FSM.
    always_comb begin
        state_next = state_reg;
        req_fire   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // A full skid buffer blocks fetch so that a response and a
                // buffer drain never compete for the output register.
                req_fire = !buf_valid_reg && !pc_src;
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (pc_src) begin
                    // Redirect: if the response is here now it is simply
                    // discarded, otherwise remember to discard it later.
                    state_next = imem_valid ? IDLE : DROP;
                end else if (imem_valid) begin
                    if (slot_free) begin
                        // Back-to-back fetch keeps one instruction per
                        // response with a single-cycle memory.
                        req_fire   = 1'b1;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                // The stale response retires the outstanding request. A
                // redirect arriving in the same cycle only moves the PC, so
                // leaving DROP here cannot orphan a response.
                if (imem_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request strobe is suppressed while reset is held.
    assign imem_req  = req_fire && !rst;
    assign imem_addr = pc_reg & 32'hFFFF_FFFC;

    // PC and request-tag update: redirect wins, otherwise advance on issue.
    always_comb begin
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        if (pc_src) begin
            pc_next = target_aligned;
        end else if (req_fire) begin
            req_pc_next = pc_reg;
            pc_next     = pc_reg + 32'd4;
        end
    end

    // Output register and skid buffer update.
    always_comb begin
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        buf_instr_next   = buf_instr_reg;
        buf_pc_next      = buf_pc_reg;
        buf_valid_next   = buf_valid_reg;
        if (pc_src) begin
            // Redirect flushes everything, even while decode is stalled.
            instr_next       = NOP_INSTR;
            instr_valid_next = 1'b0;
            buf_valid_next   = 1'b0;
        end else begin
            if (resp_to_buf) begin
                buf_instr_next = imem_rdata;
                buf_pc_next    = req_pc_reg;
                buf_valid_next = 1'b1;
            end
            if (!stall && buf_valid_reg) begin
                instr_next       = buf_instr_reg;
                instr_pc_next    = buf_pc_reg;
                instr_valid_next = 1'b1;
                buf_valid_next   = 1'b0;
            end else if (resp_to_out) begin
                instr_next       = imem_rdata;
                instr_pc_next    = req_pc_reg;
                instr_valid_next = 1'b1;
            end else if (!stall) begin
                instr_next       = NOP_INSTR;
                instr_valid_next = 1'b0;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            req_pc_reg      <= 32'd0;
            instr_reg       <= NOP_INSTR;
            instr_pc_reg    <= 32'd0;
            instr_valid_reg <= 1'b0;
            buf_instr_reg   <= 32'd0;
            buf_pc_reg      <= 32'd0;
            buf_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            req_pc_reg      <= req_pc_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            buf_instr_reg   <= buf_instr_next;
            buf_pc_reg      <= buf_pc_next;
            buf_valid_reg   <= buf_valid_next;
        end
    end

    assign instr       = instr_reg;
    assign opcode      = instr_reg[6:0];
    assign instr_pc    = instr_pc_reg;
    assign instr_pc4   = instr_pc_reg + 32'd4;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run of fetch_stage
// against a program-order reference model and a latency-programmable memory.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    // memory model state
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          wait_cnt = 0;
    int          mem_lat = 1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_rdata = 32'd0;

    assign imem_valid = mem_valid | inj_valid;
    assign imem_rdata = inj_valid ? inj_rdata : mem_rdata;

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .pc_src(pc_src), .pc_target(pc_target), .stall(stall),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
        .instr_pc4(instr_pc4), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Instruction memory: one response per request after mem_lat edges
    // (mem_lat==0 picks 1..3 at random per request).
    always @(posedge clk) begin
        automatic logic        req_seen = imem_req;
        automatic logic        valid_now = mem_valid;
        automatic logic [31:0] a = imem_addr;
        #1;
        if (rst) begin
            pending   = 1'b0;
            mem_valid = 1'b0;
            mem_rdata = $urandom;
        end else begin
            if (valid_now) pending = 1'b0;
            if (req_seen) begin
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL single_outstanding: new request 0x%08h while 0x%08h still pending", a, pend_addr);
                end
                pending   = 1'b1;
                pend_addr = a;
                wait_cnt  = (mem_lat == 0) ? int'($urandom_range(0, 2)) : mem_lat - 1;
            end else if (pending && wait_cnt > 0) begin
                wait_cnt--;
            end
            mem_valid = pending && (wait_cnt == 0);
            mem_rdata = mem_valid ? word_at(pend_addr) : $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1; stall = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
        inj_valid = 1'b0; mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
        checks++; if (opcode !== 7'd19) begin errors++; $display("FAIL reset_opcode: got %0d expected 19", opcode); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
        checks++; if (instr_pc4 !== 32'd4) begin errors++; $display("FAIL reset_pc4: got %h expected 4", instr_pc4); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, RPC + 32'(4 * k)); end
            if (k < 2) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d]: got %b expected 0", k, instr_valid); end
            end else begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== RPC + 32'(4 * (k - 2)) || instr_pc4 !== RPC + 32'(4 * (k - 1)) || instr !== word_at(RPC + 32'(4 * (k - 2)))) begin
                    errors++;
                    $display("FAIL stream_out[%0d]: got v=%b pc=%h pc4=%h instr=%h expected v=1 pc=%h pc4=%h instr=%h", k, instr_valid, instr_pc, instr_pc4, instr, RPC + 32'(4 * (k - 2)), RPC + 32'(4 * (k - 1)), word_at(RPC + 32'(4 * (k - 2))));
                end
            end
            step();
        end
        $display("test_stream done");
    endtask

    task automatic test_stall_skid();
        do_reset(1);
        step();                 // k=0: request 0x100
        step();                 // k=1: 0x100 returns, request 0x104
        stall = 1'b1;           // k=2: 0x104 returns while output is held
        @(negedge clk);
        checks++; if (instr_pc !== RPC || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_out: got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, RPC); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_k2: got %b expected 0", imem_req); end
        step();
        @(negedge clk);         // k=3: buffer full, still stalled
        checks++; if (instr_pc !== RPC || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold: got pc=%h req=%b expected pc=%h req=0", instr_pc, imem_req, RPC); end
        step();
        stall = 1'b0;           // k=4: buffer drains this edge
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_drain: got %b expected 0", imem_req); end
        step();
        @(negedge clk);         // k=5
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RPC + 32'd4 || instr !== word_at(RPC + 32'd4)) begin errors++; $display("FAIL skid_out: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", instr_valid, instr_pc, instr, RPC + 32'd4, word_at(RPC + 32'd4)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC + 32'd8) begin errors++; $display("FAIL skid_next_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC + 32'd8); end
        $display("test_stall_skid done");
    endtask

    task automatic test_redirect_wait();
        logic found;
        logic seen;
        do_reset(3);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr === 32'h10C) found = 1'b1;
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL redir_wait_setup: request 0x10c seen=0 expected 1"); end
        pc_src = 1'b1; pc_target = 32'h0000_0203;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_wait_req: got %b expected 0", imem_req); end
        step();
        pc_src = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_flush: got valid=%b pc=%h expected valid=0", instr_valid, instr_pc); end
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL redir_wait_target: got %h expected 00000200", imem_addr); end
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL redir_wait_timeout: no request after redirect"); end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                checks++; if (instr_pc !== 32'h200 || instr !== word_at(32'h200)) begin errors++; $display("FAIL redir_wait_first: got pc=%h instr=%h expected pc=00000200 instr=%h", instr_pc, instr, word_at(32'h200)); end
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL redir_wait_deliver: target never delivered"); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_flush();
        // Redirect in the same cycle a response arrives with decode stalled.
        do_reset(1);
        step(); step();
        stall = 1'b1; pc_src = 1'b1; pc_target = 32'h300;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_a_req: got %b expected 0", imem_req); end
        step();
        stall = 1'b0; pc_src = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== NOP || opcode !== 7'h13) begin errors++; $display("FAIL flush_a_out: got v=%b instr=%h op=%h expected v=0 instr=%h op=13", instr_valid, instr, opcode, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL flush_a_target: got req=%b addr=%h expected req=1 addr=00000300", imem_req, imem_addr); end
        step(); step();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin errors++; $display("FAIL flush_a_first: got v=%b pc=%h expected v=1 pc=00000300", instr_valid, instr_pc); end
        // Redirect while both output and skid buffer hold data.
        do_reset(1);
        step(); step();
        stall = 1'b1;
        step();
        pc_src = 1'b1; pc_target = 32'h400;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_b_req: got %b expected 0", imem_req); end
        step();
        pc_src = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL flush_b_out: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL flush_b_target: got req=%b addr=%h expected req=1 addr=00000400", imem_req, imem_addr); end
        step(); step();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin errors++; $display("FAIL flush_b_first: got v=%b pc=%h expected v=1 pc=00000400", instr_valid, instr_pc); end
        $display("test_redirect_flush done");
    endtask

    task automatic test_wrap();
        do_reset(1);
        pc_src = 1'b1; pc_target = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %b expected 0", imem_req); end
        step();
        pc_src = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
        step();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        step();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h expected v=1 pc=fffffffc pc4=00000000", instr_valid, instr_pc, instr_pc4); end
        $display("test_wrap done");
    endtask

    task automatic test_async_reset();
        logic seen;
        do_reset(3);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) seen = 1'b1;
            else step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL areset_setup: no instruction before reset"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'd0 || instr_pc4 !== 32'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL areset_immediate: got v=%b instr=%h pc=%h pc4=%h req=%b expected v=0 instr=%h pc=0 pc4=4 req=0", instr_valid, instr, instr_pc, instr_pc4, imem_req, NOP); end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0; inj_valid = 1'b1; inj_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL areset_restart: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC); end
        step();
        inj_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                checks++; if (instr_pc !== RPC || instr !== word_at(RPC)) begin errors++; $display("FAIL areset_first: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, RPC, word_at(RPC)); end
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL areset_deliver: nothing delivered after reset"); end
        $display("test_async_reset done");
    endtask

    // Program-order model: every live instruction must be the next address
    // after the last one decode accepted (or the latest redirect target), and
    // a stalled live instruction must not change.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        held;
        logic [31:0] h_pc;
        logic [31:0] h_instr;
        int          delivered;
        do_reset(0);
        exp_pc = RPC; held = 1'b0; h_pc = 32'd0; h_instr = 32'd0; delivered = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++; if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align: got addr=%h expected low bits 00", imem_addr); end
            checks++; if (instr_pc4 !== instr_pc + 32'd4 || opcode !== instr[6:0]) begin errors++; $display("FAIL rnd_derived: got pc4=%h op=%h for pc=%h instr=%h", instr_pc4, opcode, instr_pc, instr); end
            if (held) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== h_pc || instr !== h_instr) begin errors++; $display("FAIL rnd_hold: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", instr_valid, instr_pc, instr, h_pc, h_instr); end
            end
            if (instr_valid === 1'b1) begin
                checks++; if (instr_pc !== exp_pc || instr !== word_at(exp_pc)) begin errors++; $display("FAIL rnd_order: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, exp_pc, word_at(exp_pc)); end
            end else begin
                checks++; if (instr !== NOP) begin errors++; $display("FAIL rnd_nop: got instr=%h expected %h", instr, NOP); end
            end
            held = instr_valid && stall && !pc_src;
            h_pc = instr_pc; h_instr = instr;
            if (pc_src) begin
                exp_pc = pc_target & 32'hFFFF_FFFC;
            end else if (instr_valid && !stall) begin
                $display("accept pc=%h instr=%h", instr_pc, instr);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            step();
            stall     = ($urandom_range(0, 3) == 0);
            pc_src    = ($urandom_range(0, 19) == 0);
            pc_target = $urandom;
        end
        checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress: got %0d accepted expected at least 50", delivered); end
        stall = 1'b0; pc_src = 1'b0;
        $display("test_random done: %0d accepted", delivered);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
